// File: rtl/capture_reader.sv
// capture_reader: fetches a run of I/Q samples from the capture buffer, one
// outstanding read at a time, and presents them as a valid/ready stream.
module capture_reader #(
  parameter int unsigned CAP_I_BITS        = 12,
  parameter int unsigned CAP_Q_BITS        = 12,
  parameter int unsigned CAP_INDEX_BITS    = 10,
  parameter int unsigned CAP_BUFFER_LENGTH = 1024
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [CAP_INDEX_BITS-1:0]    start_addr,
  input  logic [CAP_INDEX_BITS:0]      read_len,
  input  logic                         abort,
  output logic                         busy,
  output logic                         done,
  output logic [CAP_INDEX_BITS-1:0]    m_axi_cap_raddr,
  output logic                         m_axi_cap_rvalid,
  input  logic                         s_axi_cap_rready,
  input  logic                         s_axi_cap_rvalid,
  input  logic signed [CAP_I_BITS-1:0] cap_i,
  input  logic signed [CAP_Q_BITS-1:0] cap_q,
  output logic                         m_axi_cap_rready,
  output logic signed [CAP_I_BITS-1:0] out_i,
  output logic signed [CAP_Q_BITS-1:0] out_q,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_last
);

  localparam int unsigned LenW = CAP_INDEX_BITS + 1;
  localparam logic [LenW-1:0] LenMax = LenW'(CAP_BUFFER_LENGTH);
  localparam logic [LenW-1:0] LenOne = LenW'(1);
  localparam logic [CAP_INDEX_BITS-1:0] AddrLast = CAP_INDEX_BITS'(CAP_BUFFER_LENGTH - 1);
  localparam logic [CAP_INDEX_BITS-1:0] AddrOne = CAP_INDEX_BITS'(1);

  typedef enum logic [1:0] {StIdle, StAddr, StData, StDrain} state_e;

  state_e                       state_q, state_d;
  logic [CAP_INDEX_BITS-1:0]    addr_q, addr_d;
  logic [LenW-1:0]              cnt_q, cnt_d;
  logic                         abort_q, abort_d;
  logic                         done_q, done_d;
  logic signed [CAP_I_BITS-1:0] oi_q, oi_d;
  logic signed [CAP_Q_BITS-1:0] oq_q, oq_d;
  logic                         ov_q, ov_d;
  logic                         ol_q, ol_d;
  logic [LenW-1:0]              len_clamped;
  logic                         beat;

  assign len_clamped      = (read_len > LenMax) ? LenMax : read_len;
  assign busy             = (state_q != StIdle);
  assign done             = done_q;
  assign m_axi_cap_raddr  = addr_q;
  assign m_axi_cap_rvalid = (state_q == StAddr);
  // While aborting, the pending beat is always accepted so it can be discarded.
  assign m_axi_cap_rready = (state_q == StData) && (abort_q || !ov_q || out_ready);
  assign beat             = m_axi_cap_rready && s_axi_cap_rvalid;
  assign out_i            = oi_q;
  assign out_q            = oq_q;
  assign out_valid        = ov_q;
  assign out_last         = ol_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      cnt_q   <= '0;
      abort_q <= 1'b0;
      done_q  <= 1'b0;
      oi_q    <= '0;
      oq_q    <= '0;
      ov_q    <= 1'b0;
      ol_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
      done_q  <= done_d;
      oi_q    <= oi_d;
      oq_q    <= oq_d;
      ov_q    <= ov_d;
      ol_q    <= ol_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    abort_d = abort_q;
    done_d  = 1'b0;
    oi_d    = oi_q;
    oq_d    = oq_q;
    ov_d    = ov_q;
    ol_d    = ol_q;

    if (ov_q && out_ready) begin
      ov_d = 1'b0;
      ol_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (abort) begin
          ov_d = 1'b0;
          ol_d = 1'b0;
        end else if (start) begin
          if (len_clamped == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = StAddr;
            addr_d  = start_addr;
            cnt_d   = len_clamped;
          end
        end
      end
      StAddr: begin
        // An accepted address owes a data beat, so it must be collected even on abort.
        if (s_axi_cap_rready) begin
          state_d = StData;
          if (abort) begin
            abort_d = 1'b1;
            ov_d    = 1'b0;
            ol_d    = 1'b0;
          end
        end else if (abort) begin
          state_d = StIdle;
          ov_d    = 1'b0;
          ol_d    = 1'b0;
        end
      end
      StData: begin
        if (abort || abort_q) begin
          ov_d = 1'b0;
          ol_d = 1'b0;
          if (beat) begin
            state_d = StIdle;
            abort_d = 1'b0;
          end else begin
            abort_d = 1'b1;
          end
        end else if (beat) begin
          oi_d  = cap_i;
          oq_d  = cap_q;
          ov_d  = 1'b1;
          ol_d  = (cnt_q == LenOne);
          cnt_d = cnt_q - LenOne;
          if (cnt_q == LenOne) begin
            state_d = StDrain;
          end else begin
            state_d = StAddr;
            addr_d  = (addr_q == AddrLast) ? '0 : addr_q + AddrOne;
          end
        end
      end
      StDrain: begin
        if (abort) begin
          state_d = StIdle;
          ov_d    = 1'b0;
          ol_d    = 1'b0;
        end else if (ov_q && out_ready && ol_q) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule
